// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receive path.
package uart_pkg;
    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver strobe, consumer handshake and status bundle for uart_rx_fifo.
interface uart_rx_fifo_if #(
    parameter int DEPTH      = uart_pkg::UART_FIFO_DEPTH,
    parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);
    logic                       i_rx_valid;
    logic [DATA_WIDTH-1:0]      i_rx_byte;
    logic                       o_data_valid;
    logic                       i_data_ready;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_empty;
    logic                       o_full;
    logic [$clog2(DEPTH):0]     o_level;
    logic                       o_overflow;
    logic                       i_clear_overflow;

    modport slave (
        input  i_rx_valid, i_rx_byte, i_data_ready, i_clear_overflow,
        output o_data_valid, o_data, o_empty, o_full, o_level, o_overflow
    );
    modport master (
        output i_rx_valid, i_rx_byte, i_data_ready, i_clear_overflow,
        input  o_data_valid, o_data, o_empty, o_full, o_level, o_overflow
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: register array with one write port and one asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) mem_q[i_waddr] <= i_wdata;

    assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO behind the UART receiver with sticky overflow.
// Define UART_RX_FIFO_DROP_OLDEST_EN to overwrite the oldest entry on overflow instead of dropping the new byte.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_FIFO_DEPTH,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push, ovf_evt, we;

    always_comb begin
        empty   = wr_ptr_q == rd_ptr_q;
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && bus.i_data_ready;
        push    = bus.i_rx_valid && (!full || pop);
        ovf_evt = bus.i_rx_valid && full && !pop;
`ifdef UART_RX_FIFO_DROP_OLDEST_EN
        // overflow overwrites the oldest slot and slides the window forward
        we       = push || ovf_evt;
        rd_ptr_d = rd_ptr_q + PW'(pop || ovf_evt);
`else
        we       = push;
        rd_ptr_d = rd_ptr_q + PW'(pop);
`endif
        wr_ptr_d = wr_ptr_q + PW'(we);
        ovf_d    = ovf_evt ? 1'b1 : bus.i_clear_overflow ? 1'b0 : ovf_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end

    uart_fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (wr_ptr_q[AW-1:0]),
        .i_wdata (bus.i_rx_byte),
        .i_raddr (rd_ptr_q[AW-1:0]),
        .o_rdata (bus.o_data)
    );

    assign bus.o_empty      = empty;
    assign bus.o_full       = full;
    assign bus.o_data_valid = !empty;
    assign bus.o_level      = wr_ptr_q - rd_ptr_q;
    assign bus.o_overflow   = ovf_q;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO that sits directly downstream of the UART receiver. It captures each single-cycle valid strobe plus byte from the receiver and buffers it in a circular store. It presents the bytes to the consuming logic through a valid/ready handshake. Overflow is flagged with a sticky status bit, so bursts arriving while the consumer is stalled are either absorbed or reported, never silently lost.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2.
- DATA_WIDTH, 8: bits per entry.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_rx_valid  in  1  single-cycle strobe from the receiver; the byte is valid this cycle.
- i_rx_byte  in  DATA_WIDTH  received byte, sampled when i_rx_valid=1.
- o_data_valid  out  1  head entry available; equals !o_empty.
- i_data_ready  in  1  consumer accepts the head; a pop occurs when o_data_valid && i_data_ready.
- o_data  out  DATA_WIDTH  head entry (show-ahead); undefined content when o_data_valid=0.
- o_empty  out  1  level==0.
- o_full  out  1  level==DEPTH.
- o_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky; set when a strobe arrives while full and no pop occurs that cycle.
- i_clear_overflow  in  1  synchronous clear of o_overflow.

## Operation
- Storage: DEPTH×DATA_WIDTH register array.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- o_level = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push: i_rx_valid=1 and (!o_full, or a pop in the same cycle). Writes mem[wr_ptr low bits] and increments wr_ptr.
- Pop: o_data_valid && i_data_ready. Increments rd_ptr. i_data_ready while empty is ignored.
- Simultaneous push and pop:
  - Both occur; level is unchanged.
  - When full, the pop frees a slot and the push is accepted; o_overflow is not set.
  - When empty, only the push occurs; there is no bypass path.
- Overflow (push attempted, full, no pop):
  - Byte is handled per Configuration.
  - o_overflow <= 1.
- o_overflow clear:
  - i_clear_overflow=1 clears it.
  - If an overflow event and i_clear_overflow coincide in the same cycle, set wins.
- Pointers wrap naturally through 2·DEPTH; no special case is needed.
- No state machine beyond the pointers and the flag. Input strobes arrive at most once per bit-period × 10, but the block supports back-to-back strobes every cycle.

## Timing
- Reset values: wr_ptr=rd_ptr=0; o_empty=1, o_full=0, o_level=0, o_data_valid=0, o_overflow=0. o_data is don't-care; array contents are not reset.
- Reset asserted mid-operation clears all pointers and flags immediately (asynchronous). All buffered bytes are discarded.
- Write latency: strobe at edge N → o_data_valid=1 and o_data=byte after edge N+1 (one cycle).
- Pop takes effect at the same edge. The next entry appears on o_data in the following cycle, combinationally from the array.
- o_level, o_full, o_empty and o_overflow are registered or decoded from registered pointers; none depend combinationally on i_data_ready.

## Configuration
- UART_RX_FIFO_DROP_OLDEST_EN defined:
  - On overflow, the new byte is written at wr_ptr and both wr_ptr and rd_ptr increment.
  - The oldest entry is discarded; level stays DEPTH.
- Not defined (default):
  - On overflow, the incoming byte is discarded; pointers are unchanged.
- o_overflow behaves identically in both builds.

## Structure
- The shared package uart_pkg holds UART_DATA_WIDTH (8) and the default FIFO depth constant.
- One sub-module: uart_fifo_mem (register array, one write port, one asynchronous read port), so it can later be swapped for block RAM.
- Pointer, flag and level logic lives in uart_rx_fifo.

## Test plan
- Reset, then strobe 0xA5 while i_data_ready=0 → one cycle later o_data_valid=1, o_data=0xA5, o_level=1. Assert ready for 1 cycle → o_empty=1.
- Push 16 bytes 0x00..0x0F, then pop all → output order 0x00..0x0F; o_full=1 after the 16th push; o_overflow stays 0.
- Full, push 0xEE with no pop:
  - Default build: o_overflow=1, head still 0x00, 0xEE absent.
  - DROP_OLDEST build: o_overflow=1, head becomes 0x01, last entry 0xEE.
- Full, push 0x55 and pop in the same cycle → o_level stays 16, o_overflow=0, 0x55 is read last.
- Stream 40 bytes with alternating push/pop so the pointers wrap twice → data is intact and in order; o_level never exceeds 2.
- Assert i_rst_n=0 for one cycle with level 7 → o_level=0, o_empty=1, o_overflow=0 immediately. A subsequent push of 0x3C reads back as 0x3C.
